instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle MIPS datapath. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered with their PCs in a small prefetch FIFO and presented to the decode/execute stage over a valid/ready interface. A redirect input flushes the buffer and restarts fetch at a new address.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read channel plus decode-side
// instruction stream.
//   master : the fetch unit (drives mem_req_o/mem_addr_o and the inst stream)
//   slave  : memory + consumer side (drives ack/data and inst_ready_i)
interface instr_fetch_unit_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  mem_ack_i, mem_data_i, inst_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output mem_ack_i, mem_data_i, inst_ready_i
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one-outstanding word reads
// over a req/ack handshake, buffers returned words with their PCs in a small
// prefetch FIFO and presents the head over valid/ready. A redirect flushes the
// FIFO and restarts fetch at the (word-aligned) target.
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i        fetch enable
//   redirect_i     flush + reload fetch PC from redirect_pc_i
//   bus            memory channel and instruction stream (master side)
//   count_o        FIFO occupancy
//   misalign_o     sticky misaligned-redirect flag
// Optional feature: define IFU_ALIGN_CHECK_EN to enable the misalign check;
// otherwise misalign_o is tied low.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_pc_i,
    instr_fetch_unit_if.master      bus,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    misalign_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t         state_q, state_d;
    logic           req_q, req_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    redir_pc;

    logic [31:0]    fifo_inst_q [DEPTH];
    logic [31:0]    fifo_pc_q   [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_nxt;

    logic           ack, push, pop, can_issue;

    assign redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;
    assign ack       = req_q && bus.mem_ack_i;
    // Only a live (non-discarded) transfer not overlapped by a redirect is kept.
    assign push      = ack && (state_q == REQ) && !redirect_i;
    assign pop       = (count_q != '0) && bus.inst_ready_i;
    assign count_nxt = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    // Issue only if the slot is guaranteed free when the ack returns.
    assign can_issue = start_i && (count_nxt < CW'(DEPTH));

    // State / request registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and request control
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        if (redirect_i) begin
            pc_d = redir_pc;
        end
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                end
            end
            REQ: begin
                if (redirect_i && !ack) begin
                    state_d = DISCARD;
                end else if (ack) begin
                    if (!redirect_i) begin
                        pc_d = pc_q + 32'd4;
                    end
                    if (can_issue) begin
                        addr_d = pc_d;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DISCARD: begin
                // Stale transfer completes; its data is dropped.
                if (ack) begin
                    if (can_issue) begin
                        state_d = REQ;
                        addr_d  = pc_d;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Prefetch FIFO
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_inst_q[wr_ptr_q] <= bus.mem_data_i;
                    fifo_pc_q[wr_ptr_q]   <= addr_q;
                    wr_ptr_q              <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
            count_q <= count_nxt;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic misalign_q;

    // Sticky flag for redirect targets that are not word aligned
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            misalign_q <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign bus.mem_req_o    = req_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.inst_valid_o = (count_q != '0);
    assign bus.inst_o       = fifo_inst_q[rd_ptr_q];
    assign bus.inst_pc_o    = fifo_pc_q[rd_ptr_q];
    assign count_o          = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (queue of {pc, inst} plus one outstanding read).
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_ALIGN_CHECK_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    start_i;
    logic                    redirect_i;
    logic [31:0]             redirect_pc_i;
    logic [$clog2(DEPTH):0]  count_o;
    logic                    misalign_o;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .bus           (bus),
        .count_o       (count_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] q[$];          // {pc, inst}, head at index 0
    logic [31:0] m_fetch_pc;
    logic        m_out;         // a read is outstanding
    logic [31:0] m_out_addr;
    logic        m_out_drop;    // outstanding read was killed by a redirect
    logic        m_mis;

    task automatic model_reset();
        q.delete();
        m_fetch_pc = RESET_PC;
        m_out      = 1'b0;
        m_out_addr = RESET_PC;
        m_out_drop = 1'b0;
        m_mis      = 1'b0;
    endtask

    task automatic model_step();
        logic acked;
        acked = m_out && bus.mem_ack_i;
        if (redirect_i) begin
            q.delete();
            m_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
            if (ALIGN && redirect_pc_i[1:0] != 2'b00) m_mis = 1'b1;
            if (acked) m_out = 1'b0;
            else if (m_out) m_out_drop = 1'b1;
        end else begin
            if (q.size() != 0 && bus.inst_ready_i) void'(q.pop_front());
            if (acked) begin
                if (!m_out_drop) begin
                    q.push_back({m_out_addr, bus.mem_data_i});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                m_out = 1'b0;
            end
        end
        if (!m_out && start_i && q.size() < int'(DEPTH)) begin
            m_out      = 1'b1;
            m_out_addr = m_fetch_pc;
            m_out_drop = 1'b0;
        end
    endtask

    always @(posedge clk_i) if (rst_i) model_step();

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("mem_req", 32'(bus.mem_req_o), 32'(m_out));
            if (m_out) check("mem_addr", bus.mem_addr_o, m_out_addr);
            check("count", 32'(count_o), 32'(q.size()));
            check("inst_valid", 32'(bus.inst_valid_o), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("inst", bus.inst_o, q[0][31:0]);
                check("inst_pc", bus.inst_pc_o, q[0][63:32]);
            end
            check("misalign", 32'(misalign_o), 32'(m_mis));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                         input logic a, input logic [31:0] d, input logic rd);
        start_i          = s;
        redirect_i       = r;
        redirect_pc_i    = rp;
        bus.mem_ack_i    = a;
        bus.mem_data_i   = d;
        bus.inst_ready_i = rd;
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] rp,
                       input logic a, input logic [31:0] d, input logic rd);
        drive(s, r, rp, a, d, rd);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_i  = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_i);

        // Reset values
        check("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        check("rst_mem_addr", bus.mem_addr_o, RESET_PC);
        check("rst_inst_valid", 32'(bus.inst_valid_o), 32'h0);
        check("rst_inst", bus.inst_o, 32'h0);
        check("rst_inst_pc", bus.inst_pc_o, 32'h0);
        check("rst_count", 32'(count_o), 32'h0);
        check("rst_misalign", 32'(misalign_o), 32'h0);
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // Zero-wait streaming: one instruction per cycle, count steady at 1
        cyc(1, 0, 0, 1, 32'h1000_0000, 1);
        check("stream_req", 32'(bus.mem_req_o), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 1, 32'h1000_0000 + 32'(i + 1), 1);
            check("stream_pc", bus.inst_pc_o, 32'(i * 4));
            check("stream_count", 32'(count_o), 32'h1);
        end

        // Fill with consumer stalled, then free one slot
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 32'h2000_0000 + 32'(i), 0);
        check("full_count", 32'(count_o), 32'd4);
        check("full_req", 32'(bus.mem_req_o), 32'h0);
        check("full_head_pc", bus.inst_pc_o, 32'h0);
        cyc(1, 0, 0, 1, 32'h2000_00AA, 1);
        check("pop1_req", 32'(bus.mem_req_o), 32'h1);
        check("pop1_count", 32'(count_o), 32'd3);
        check("pop1_addr", bus.mem_addr_o, 32'h10);
        check("pop1_head_pc", bus.inst_pc_o, 32'h4);
        cyc(1, 0, 0, 1, 32'h2000_00BB, 0);
        check("refill_count", 32'(count_o), 32'd4);
        check("refill_req", 32'(bus.mem_req_o), 32'h0);
        repeat (3) cyc(1, 0, 0, 1, 32'h0, 0);
        check("refill_stay", 32'(bus.mem_req_o), 32'h0);

        // Slow memory: address held while waiting; start dropping does not abort
        do_reset();
        cyc(1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            check("wait_req", 32'(bus.mem_req_o), 32'h1);
            check("wait_addr", bus.mem_addr_o, 32'h0);
            if (i < 3) cyc(0, 0, 0, 0, 32'h0, 0);
        end
        cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        check("slow_valid", 32'(bus.inst_valid_o), 32'h1);
        check("slow_inst", bus.inst_o, 32'hDEAD_BEEF);
        check("slow_pc", bus.inst_pc_o, 32'h0);
        check("slow_req", 32'(bus.mem_req_o), 32'h0);

        // Redirect with a read outstanding at 0x8
        do_reset();
        repeat (3) cyc(1, 0, 0, 1, 32'h3000_0000, 0);
        check("redir_pre_addr", bus.mem_addr_o, 32'h8);
        cyc(1, 1, 32'h100, 0, 32'h0, 0);
        check("redir_count", 32'(count_o), 32'h0);
        check("redir_valid", 32'(bus.inst_valid_o), 32'h0);
        check("redir_hold_addr", bus.mem_addr_o, 32'h8);
        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 1, 32'hBAD0_0008, 0);
        check("redir_new_addr", bus.mem_addr_o, 32'h100);
        check("redir_drop_count", 32'(count_o), 32'h0);
        cyc(1, 0, 0, 1, 32'h0000_0100, 0);
        check("redir_first_pc", bus.inst_pc_o, 32'h100);
        check("redir_first_inst", bus.inst_o, 32'h0000_0100);

        // Misaligned redirect target (ack in the same cycle)
        cyc(1, 1, 32'h203, 1, 32'hBAD0_0000, 0);
        check("mis_addr", bus.mem_addr_o, 32'h200);
        check("mis_count", 32'(count_o), 32'h0);
        check("mis_flag", 32'(misalign_o), 32'(ALIGN));
        repeat (2) cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h0000_0200, 0);
        check("mis_sticky", 32'(misalign_o), 32'(ALIGN));
        check("mis_data_pc", bus.inst_pc_o, 32'h200);

        // Reset in the middle of a transfer with 3 entries buffered
        do_reset();
        check("rst2_misalign", 32'(misalign_o), 32'h0);
        repeat (4) cyc(1, 0, 0, 1, 32'h4000_0000, 0);
        check("mid_count", 32'(count_o), 32'd3);
        check("mid_req", 32'(bus.mem_req_o), 32'h1);
        chk_en = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 0);
        #2 rst_i = 1'b0;
        model_reset();
        #1;
        check("midrst_req", 32'(bus.mem_req_o), 32'h0);
        check("midrst_count", 32'(count_o), 32'h0);
        check("midrst_valid", 32'(bus.inst_valid_o), 32'h0);
        @(negedge clk_i);
        rst_i  = 1'b1;
        chk_en = 1'b1;
        cyc(1, 0, 0, 0, 32'h0, 0);
        check("restart_req", 32'(bus.mem_req_o), 32'h1);
        check("restart_addr", bus.mem_addr_o, RESET_PC);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0), $urandom,
                $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 9) < 6));
        end

        drive(0, 0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
